// File: rtl/rand_buffer.sv
// Buffers random words from the upstream generator in a small FWFT FIFO.
// The head word is also exposed as a threshold hit and as an index scaled into [0, range).
module rand_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         rand_in,
  input  logic                     rand_strobe,
  input  logic                     out_ready,
  input  logic [WIDTH-1:0]         prob_thresh,
  input  logic [15:0]              range,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_hit,
  output logic [15:0]              out_idx,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [LW-1:0]    level_next;
  logic [31:0]      prod;

  // Handshake decode; a full FIFO still accepts a word when the head leaves this cycle.
  always_comb begin
    full       = (level == LW'(DEPTH));
    pop        = out_valid & out_ready;
    push       = rand_strobe & (~full | pop);
    drop       = rand_strobe & full & ~pop;
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level     <= level_next;
      out_valid <= (level_next != '0);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage is not reset; it is hidden behind out_valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rand_in;
  end

  // Head-word views: FWFT data, threshold compare and multiply-shift range scaling.
  always_comb begin
    out_data = mem[rd_ptr];
    out_hit  = (out_data < prob_thresh);
    prod     = 32'(out_data[WIDTH-1 -: 16]) * 32'(range);
    out_idx  = 16'(prod >> 16);
  end

endmodule

// File: doc/rand_buffer.md
RAND_BUFFER -- requirements
Module: rand_buffer

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO depth in words; it is a power of two, at least 2.
REQ-002 Parameter WIDTH, default 32, SHALL set the random word width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 rand_in  input  WIDTH  SHALL carry the random word from the upstream xorwow generator.
REQ-006 rand_strobe  input  1  SHALL be a one-cycle pulse marking rand_in as a new word to capture.
REQ-007 out_ready  input  1  SHALL be the consumer's request to take the head word.
REQ-008 prob_thresh  input  WIDTH  SHALL be the unsigned probability threshold for out_hit.
REQ-009 range  input  16  SHALL be the index range for out_idx.
REQ-010 out_valid  output  1  SHALL be high when the FIFO holds at least one word.
REQ-011 out_data  output  WIDTH  SHALL be the head word, first-word-fall-through.
REQ-012 out_hit  output  1  SHALL be the head-word threshold compare result.
REQ-013 out_idx  output  16  SHALL be the head word scaled into [0, range).
REQ-014 level  output  log2(DEPTH)+1  SHALL be the current occupancy, 0..DEPTH.
REQ-015 drop_cnt  output  8  SHALL count words dropped on overflow.

Function
REQ-016 Push SHALL occur on a rising edge with rand_strobe=1 and either level<DEPTH or a simultaneous pop.
REQ-017 Pop SHALL occur on a rising edge with out_valid=1 and out_ready=1; out_ready with out_valid=0 SHALL have no effect.
REQ-018 Storage SHALL be a circular buffer with write and read pointers wrapping from DEPTH-1 to 0.
REQ-019 A pushed word SHALL appear on out_data with out_valid=1 on the cycle after the push edge when the FIFO was empty; there is no same-cycle bypass.
REQ-020 out_data, out_hit and out_idx SHALL be combinational from the head entry; they are don't-care while out_valid=0.
REQ-021 level SHALL increment on push only, decrement on pop only, and hold on simultaneous push and pop.
REQ-022 When full with rand_strobe=1 and no pop, the word SHALL be discarded and drop_cnt incremented, saturating at 255.
REQ-023 When full with push and pop in the same cycle, both SHALL occur; level stays DEPTH and drop_cnt is unchanged.
REQ-024 When empty with push and out_ready in the same cycle, only the push SHALL occur.
REQ-025 out_hit SHALL equal (out_data < prob_thresh), unsigned: prob_thresh=0 gives never; all-ones hits every word except all-ones.
REQ-026 out_idx SHALL equal (out_data[WIDTH-1:WIDTH-16] * range) >> 16, with a 32-bit product, so out_idx < range whenever range > 0.
REQ-027 range=0 SHALL give out_idx=0.
REQ-028 prob_thresh and range SHALL be sampled combinationally and can change on any cycle.

Reset
REQ-029 Asserting rst low SHALL immediately clear both pointers, level, drop_cnt and out_valid to 0, independent of clk.
REQ-030 Storage contents need not be cleared; they SHALL be unobservable while out_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words.
REQ-032 rand_strobe and out_ready SHALL be ignored while rst is low.
REQ-033 The first push SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-034 Reset, then one strobe with rand_in=0x075BCD15 and out_ready=0 -> next cycle out_valid=1, out_data=0x075BCD15, level=1.
REQ-035 prob_thresh=0x80000000 with head words 0x7FFFFFFF then 0x80000000 -> out_hit=1 then 0.
REQ-036 range=10 with head 0xFFFF0000 -> out_idx=9; range=10 with head 0x00001234 -> out_idx=0; range=0 -> out_idx=0.
REQ-037 Ten strobes with out_ready=0 (DEPTH=8) -> level=8, drop_cnt=2, pop order matches the first eight words; 300 overflow strobes -> drop_cnt=255.
REQ-038 Full FIFO with strobe and out_ready in one cycle -> level stays 8, drop_cnt unchanged, new word read last; empty FIFO with strobe and out_ready -> level=1.
REQ-039 rst pulsed low asynchronously between edges with level=5 -> level=0, out_valid=0 at once; next strobe word is the head.
